cphy_symbol_deserializer: RTL and testbench

- Sits directly downstream of the C-PHY slave pulse-generation / clock-recovery stage.
- Samples the three receiver comparator outputs (A, B, C) once per unit interval and decodes each wire-state transition into a 3-bit C-PHY symbol {Flip, Rotation, Polarity}.
- Hunts for the sync word, then groups symbols into 21-bit (7-symbol) words for the downstream 7-to-16 demapper.
- Runs on a single system clock; the recovered-clock edge arrives as a one-cycle strobe.

---
 rtl/cphy_symbol_deserializer.sv | 144 ++++++++++++++
 tb/tb_cphy_symbol_deserializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cphy_symbol_deserializer.sv
// C-PHY receive symbol deserializer: decodes wire-state transitions into 3-bit symbols,
// hunts for the sync word, then frames symbols into fixed-length words.
module cphy_symbol_deserializer #(
  parameter int                           SYMS_PER_WORD = 7,
  parameter logic [3*SYMS_PER_WORD-1:0]   SYNC_WORD     = 21'o3444443
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Enable,
  input  logic                         SymStrobe,
  input  logic                         A,
  input  logic                         B,
  input  logic                         C,
  output logic [2:0]                   SymbolOut,
  output logic                         SymbolValid,
  output logic [3*SYMS_PER_WORD-1:0]   WordOut,
  output logic                         WordValid,
  output logic                         SyncDet,
  output logic                         Locked,
  output logic                         SymErr
);

  localparam int WORD_W = 3 * SYMS_PER_WORD;
  localparam int CNT_W  = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMS_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} stateT;

  stateT             state;
  logic [2:0]        prevState;
  logic [WORD_W-1:0] shiftReg;
  logic [CNT_W-1:0]  count;

  // A wire state is valid when exactly one comparator disagrees with the other two.
  function automatic logic isValid(input logic [2:0] s);
    return (s != 3'b000) && (s != 3'b111);
  endfunction

  // The odd-one-out wire names the pair: A -> x, B -> y, C -> z.
  function automatic logic [1:0] pairOf(input logic [2:0] s);
    if (s[2] != s[1] && s[2] != s[0])
      return 2'd0;
    else if (s[1] != s[2] && s[1] != s[0])
      return 2'd1;
    else
      return 2'd2;
  endfunction

  function automatic logic [1:0] nextPair(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Positive states are one-hot, so polarity is simply the parity of the state.
  function automatic logic [2:0] decodeSym(input logic [2:0] prevS, input logic [2:0] curS);
    logic [1:0] pp;
    logic [1:0] pc;
    pp = pairOf(prevS);
    pc = pairOf(curS);
    if (pp == pc)
      return 3'b100;
    else
      return {1'b0, pc == nextPair(pp), (^curS) != (^prevS)};
  endfunction

  // Stage p0: combinational decode of the sampled wire state
  logic [2:0]        curState_p0;
  logic              curValid_p0;
  logic              noTrans_p0;
  logic [2:0]        sym_p0;
  logic [WORD_W-1:0] shifted_p0;

  assign curState_p0 = {A, B, C};
  assign curValid_p0 = isValid(curState_p0);
  assign noTrans_p0  = (curState_p0 == prevState);
  assign sym_p0      = decodeSym(prevState, curState_p0);
  assign shifted_p0  = {shiftReg[WORD_W-4:0], sym_p0};

  // Stage p1: registered FSM, framing and outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      prevState   <= 3'b000;
      shiftReg    <= '0;
      count       <= '0;
      SymbolOut   <= 3'b000;
      SymbolValid <= 1'b0;
      WordOut     <= '0;
      WordValid   <= 1'b0;
      SyncDet     <= 1'b0;
      Locked      <= 1'b0;
      SymErr      <= 1'b0;
    end else begin
      SymbolValid <= 1'b0;
      WordValid   <= 1'b0;
      SyncDet     <= 1'b0;
      SymErr      <= 1'b0;
      if (!Enable) begin
        state    <= IDLE;
        Locked   <= 1'b0;
        count    <= '0;
        shiftReg <= '0;
      end else if (SymStrobe) begin
        case (state)
          IDLE: begin
            if (curValid_p0) begin
              prevState <= curState_p0;
              state     <= HUNT;
            end
          end
          HUNT, LOCKED: begin
            if (!curValid_p0 || noTrans_p0) begin
              SymErr   <= 1'b1;
              Locked   <= 1'b0;
              count    <= '0;
              shiftReg <= '0;
              state    <= IDLE;
            end else begin
              prevState   <= curState_p0;
              SymbolOut   <= sym_p0;
              SymbolValid <= 1'b1;
              shiftReg    <= shifted_p0;
              if (state == HUNT) begin
                if (shifted_p0 == SYNC_WORD) begin
                  SyncDet <= 1'b1;
                  Locked  <= 1'b1;
                  count   <= '0;
                  state   <= LOCKED;
                end
              end else if (count == LAST_CNT) begin
                WordOut   <= shifted_p0;
                WordValid <= 1'b1;
                count     <= '0;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cphy_symbol_deserializer.sv
// Directed bench for cphy_symbol_deserializer with a queue-based behavioural model
// checked every cycle, plus hand-computed literal checks.
module tb_cphy_symbol_deserializer;

  localparam logic [2:0] PX = 3'b100, NX = 3'b011, PY = 3'b010;
  localparam logic [2:0] NY = 3'b101, PZ = 3'b001, NZ = 3'b110;
  localparam logic [20:0] SYNC = 21'o3444443;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  abc = 3'b000;
  logic [2:0]  symOut;
  logic        symValid;
  logic [20:0] wordOut;
  logic        wordValid;
  logic        syncDet;
  logic        locked;
  logic        symErr;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int wvQ[$];

  cphy_symbol_deserializer dut (
    .Clk(clk), .Rst(rst), .Enable(en), .SymStrobe(stb),
    .A(abc[2]), .B(abc[1]), .C(abc[0]),
    .SymbolOut(symOut), .SymbolValid(symValid), .WordOut(wordOut),
    .WordValid(wordValid), .SyncDet(syncDet), .Locked(locked), .SymErr(symErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0o want %0o (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]  mSym = 0, mPrev = 0;
  logic [20:0] mWord = 0;
  bit mSymV = 0, mWordV = 0, mSync = 0, mLocked = 0, mErr = 0;
  int mMode = 0;  // 0 idle, 1 hunting, 2 aligned
  int hq[$];
  int wq[$];

  function automatic bit stInfo(input logic [2:0] s, output int pair, output bit pos);
    pair = 0; pos = 0;
    case (s)
      3'b100: begin pair = 0; pos = 1; end
      3'b011: begin pair = 0; pos = 0; end
      3'b010: begin pair = 1; pos = 1; end
      3'b101: begin pair = 1; pos = 0; end
      3'b001: begin pair = 2; pos = 1; end
      3'b110: begin pair = 2; pos = 0; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic int symOf(input logic [2:0] from, input logic [2:0] to);
    int p1, p2;
    bit s1, s2, ok;
    ok = stInfo(from, p1, s1);
    ok = stInfo(to, p2, s2);
    if (p1 == p2) return 4;
    return ((p2 == (p1 + 1) % 3) ? 2 : 0) + ((s1 != s2) ? 1 : 0);
  endfunction

  function automatic int packQ(input int q[$]);
    int w = 0;
    foreach (q[i]) w = w * 8 + q[i];
    return w;
  endfunction

  always @(posedge clk) begin
    int p, s;
    bit pos;
    if (rst) begin
      mSym = 0; mPrev = 0; mWord = 0; mSymV = 0; mWordV = 0;
      mSync = 0; mLocked = 0; mErr = 0; mMode = 0;
      hq.delete(); wq.delete();
    end else begin
      mSymV = 0; mWordV = 0; mSync = 0; mErr = 0;
      if (!en) begin
        mMode = 0; mLocked = 0; hq.delete(); wq.delete();
      end else if (stb) begin
        if (mMode == 0) begin
          if (stInfo(abc, p, pos)) begin mPrev = abc; mMode = 1; end
        end else if (!stInfo(abc, p, pos) || abc == mPrev) begin
          mErr = 1; mLocked = 0; mMode = 0; hq.delete(); wq.delete();
        end else begin
          s = symOf(mPrev, abc);
          mPrev = abc; mSym = 3'(s); mSymV = 1;
          if (mMode == 1) begin
            hq.push_back(s);
            if (hq.size() > 7) void'(hq.pop_front());
            if (hq.size() == 7 && packQ(hq) == int'(SYNC)) begin
              mSync = 1; mLocked = 1; mMode = 2; hq.delete(); wq.delete();
            end
          end else begin
            wq.push_back(s);
            if (wq.size() == 7) begin
              mWord = 21'(packQ(wq)); mWordV = 1; wq.delete();
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    cmp("SymbolOut", 32'(symOut), 32'(mSym));
    cmp("SymbolValid", 32'(symValid), 32'(mSymV));
    cmp("WordOut", 32'(wordOut), 32'(mWord));
    cmp("WordValid", 32'(wordValid), 32'(mWordV));
    cmp("SyncDet", 32'(syncDet), 32'(mSync));
    cmp("Locked", 32'(locked), 32'(mLocked));
    cmp("SymErr", 32'(symErr), 32'(mErr));
    if (wordValid) wvQ.push_back(cyc);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input logic e, input logic s, input logic [2:0] v);
    @(negedge clk);
    en = e; stb = s; abc = v;
  endtask

  task automatic sendChk(input logic [2:0] v, input logic [2:0] es);
    tick(1'b1, 1'b1, v);
    tick(1'b1, 1'b0, v);
    cmp("lit SymbolValid", 32'(symValid), 32'd1);
    cmp("lit SymbolOut", 32'(symOut), 32'(es));
  endtask

  task automatic doSync();
    tick(1'b0, 1'b0, PX);
    tick(1'b1, 1'b1, PX);
    tick(1'b1, 1'b0, PX);
    sendChk(NY, 3); sendChk(PY, 4); sendChk(NY, 4); sendChk(PY, 4);
    sendChk(NY, 4); sendChk(PY, 4); sendChk(NZ, 3);
    cmp("lit SyncDet", 32'(syncDet), 32'd1);
    cmp("lit Locked", 32'(locked), 32'd1);
  endtask

  task automatic allZero(input string tag);
    cmp({tag, " SymbolOut"}, 32'(symOut), 32'd0);
    cmp({tag, " SymbolValid"}, 32'(symValid), 32'd0);
    cmp({tag, " WordOut"}, 32'(wordOut), 32'd0);
    cmp({tag, " WordValid"}, 32'(wordValid), 32'd0);
    cmp({tag, " SyncDet"}, 32'(syncDet), 32'd0);
    cmp({tag, " Locked"}, 32'(locked), 32'd0);
    cmp({tag, " SymErr"}, 32'(symErr), 32'd0);
  endtask

  logic [2:0] b2b [22] = '{PX, NY, PY, NY, PY, NY, PY, NZ,
                           NX, PY, NY, PZ, NZ, PX, NX,
                           PY, NY, PZ, NZ, PX, NX, PY};

  initial begin
    repeat (2) @(negedge clk);
    allZero("reset");
    rst = 1'b0;

    // sync acquisition from +x; no word may appear
    wvQ.delete();
    doSync();
    cmp("sync WordValid", 32'(wordValid), 32'd0);

    // first data word: -z->-x=2, ->+y=3, ->-y=4, ->+z=3, ->-z=4, ->+x=3, ->-x=4
    sendChk(NX, 2); sendChk(PY, 3); sendChk(NY, 4); sendChk(PZ, 3);
    sendChk(NZ, 4); sendChk(PX, 3);
    cmp("word early", 32'(wvQ.size()), 32'd0);
    sendChk(NX, 4);
    cmp("lit WordValid", 32'(wordValid), 32'd1);
    cmp("lit WordOut", 32'(wordOut), 32'o2343434);
    cmp("model WordOut", 32'(mWord), 32'o2343434);

    // invalid state three symbols into a word
    sendChk(PY, 3); sendChk(NY, 4); sendChk(PZ, 3);
    tick(1'b1, 1'b1, 3'b111);
    tick(1'b1, 1'b0, 3'b111);
    cmp("inv SymErr", 32'(symErr), 32'd1);
    cmp("inv Locked", 32'(locked), 32'd0);
    cmp("inv SymbolValid", 32'(symValid), 32'd0);
    cmp("inv WordValid", 32'(wordValid), 32'd0);
    tick(1'b1, 1'b1, PX);
    tick(1'b1, 1'b0, PX);
    cmp("idle absorbs", 32'(symValid), 32'd0);

    // repeated state while aligned
    doSync();
    sendChk(NX, 2);
    tick(1'b1, 1'b1, NX);
    tick(1'b1, 1'b0, NX);
    cmp("notr SymErr", 32'(symErr), 32'd1);
    cmp("notr Locked", 32'(locked), 32'd0);
    wvQ.delete();
    foreach (b2b[i]) if (i >= 8) begin
      tick(1'b1, 1'b1, b2b[i]);
      tick(1'b1, 1'b0, b2b[i]);
    end
    cmp("notr no word", 32'(wvQ.size()), 32'd0);
    cmp("notr still unlocked", 32'(locked), 32'd0);

    // enable drop after 4 symbols, then re-enable
    doSync();
    sendChk(NX, 2); sendChk(PY, 3); sendChk(NY, 4); sendChk(PZ, 3);
    wvQ.delete();
    tick(1'b0, 1'b1, NZ);
    tick(1'b0, 1'b0, NZ);
    cmp("en Locked", 32'(locked), 32'd0);
    tick(1'b1, 1'b1, NZ);
    tick(1'b1, 1'b0, NZ);
    sendChk(PX, 3); sendChk(NX, 4); sendChk(PY, 3);
    cmp("en no word", 32'(wvQ.size()), 32'd0);
    cmp("en relock", 32'(locked), 32'd0);

    // reset mid-word
    doSync();
    sendChk(NX, 2); sendChk(PY, 3); sendChk(NY, 4);
    wvQ.delete();
    @(negedge clk);
    rst = 1'b1; stb = 1'b1; abc = PZ;
    @(negedge clk);
    allZero("midrst");
    rst = 1'b0; stb = 1'b0;
    repeat (4) tick(1'b1, 1'b0, PZ);
    cmp("rst no word", 32'(wvQ.size()), 32'd0);

    // back-to-back strobes through sync and two words
    tick(1'b0, 1'b0, PX);
    wvQ.delete();
    foreach (b2b[i]) tick(1'b1, 1'b1, b2b[i]);
    repeat (3) tick(1'b1, 1'b0, PY);
    cmp("b2b words", 32'(wvQ.size()), 32'd2);
    if (wvQ.size() == 2) cmp("b2b spacing", 32'(wvQ[1] - wvQ[0]), 32'd7);
    cmp("b2b word2", 32'(wordOut), 32'o3434343);

    tick(1'b0, 1'b0, 3'b000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
